// File: rtl/pq_pkg.sv
// Shared types for the sorted priority-queue server: key/value entry and FSM states.
package pq_pkg;

  typedef struct packed {
    logic [3:0] key;
    logic [3:0] value;
  } kv_t;

  typedef enum logic {
    IDLE,
    INSERT
  } state_t;

endpackage

// File: rtl/pq_server.sv
// Priority queue held as a sorted register array; insertion walks down one slot per
// cycle, dequeue shifts the whole array up in a single cycle.
import pq_pkg::*;

module pq_server #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enq,
  input  logic deq,
  input  kv_t  kvi,
  output kv_t  kvo,
  output logic full,
  output logic empty,
  output logic busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  kv_t            q [DEPTH];
  kv_t            hold;
  kv_t            prev;
  logic [CW-1:0]  count;
  logic [IW-1:0]  idx;
  state_t         state, state_n;
  logic           acc_enq, acc_deq, ins_place;

  assign kvo   = q[0];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state == INSERT);

  always_comb begin
    state_n   = state;
    acc_enq   = 1'b0;
    acc_deq   = 1'b0;
    ins_place = 1'b0;
    prev      = q[idx - 1'b1];
    case (state)
      IDLE: begin
        // A simultaneous enq+deq always resolves to the dequeue.
        if (deq && !empty) begin
          acc_deq = 1'b1;
        end else if (enq && !deq && !full) begin
          acc_enq = 1'b1;
          state_n = INSERT;
        end
      end
      INSERT: begin
        // Stop on <= so equal keys stay behind earlier arrivals.
        if (idx == '0 || prev.key <= hold.key) begin
          ins_place = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      state <= state_n;
      if (acc_enq) begin
        idx <= IW'(count);
      end else if (state == INSERT && !ins_place) begin
        idx <= idx - 1'b1;
      end
      if (acc_deq) begin
        // Slots at and beyond count are already zero, so a full-width shift is exact.
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
        q[DEPTH-1] <= '0;
        count      <= count - 1'b1;
      end else if (state == INSERT) begin
        if (ins_place) begin
          q[idx] <= hold;
          count  <= count + 1'b1;
        end else begin
          q[idx] <= prev;
        end
      end
    end
  end

  // The held entry is only meaningful while INSERT is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (acc_enq) hold <= kvi;
  end

endmodule

// File: tb/tb_pq_server.sv
// Table-driven bench for pq_server with a scoreboard of expected post-operation state.
import pq_pkg::*;

module tb_pq_server;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enq = 1'b0;
  logic deq = 1'b0;
  kv_t  kvi;
  kv_t  kvo;
  logic full, empty, busy;

  pq_server #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(kvo), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] kvo;
    int         cnt;
    logic       emp;
    logic       ful;
  } exp_t;

  typedef struct {
    logic       e;
    logic       d;
    logic [7:0] kvi;
    int         cyc;
    logic [7:0] kvo;
    int         cnt;
    logic       emp;
    logic       ful;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[15];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm, input int nb);
    exp_t x;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard_empty"}, 1, 0);
      return;
    end
    x = sb.pop_front();
    chk({nm, " busy_cycles"}, nb, x.cyc);
    chk({nm, " kvo"}, int'(kvo), int'(x.kvo));
    chk({nm, " count"}, int'(dut.count), x.cnt);
    chk({nm, " empty"}, int'(empty), int'(x.emp));
    chk({nm, " full"}, int'(full), int'(x.ful));
  endtask

  task automatic apply(input logic e, input logic d, input logic [7:0] v,
                       input exp_t x, input string nm);
    int nb;
    sb.push_back(x);
    @(negedge clk);
    enq = e; deq = d; kvi = v;
    @(posedge clk); #1;
    enq = 1'b0; deq = 1'b0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(posedge clk); #1;
    end
    check_state(nm, nb);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " kvo"}, int'(kvo), 0);
    chk({nm, " empty"}, int'(empty), 1);
    chk({nm, " full"}, int'(full), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " count"}, int'(dut.count), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [3:0] kk;
    logic [7:0] hv;
    kvi = '0;

    //              e     d     kvi    cyc kvo    cnt emp   ful
    tbl[0]  = '{1'b1, 1'b0, 8'h55, 1, 8'h55, 1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 1, 8'h33, 1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h11, 2, 8'h11, 2, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h22, 2, 8'h11, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 0, 8'h22, 2, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 0, 8'h33, 1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h4A, 1, 8'h4A, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h4B, 1, 8'h4A, 2, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h0C, 0, 8'h4B, 1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'h77, 0, 8'h00, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h90, 1, 8'h90, 1, 1'b0, 1'b0};

    do_reset("reset0");

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].e, tbl[i].d, tbl[i].kvi,
            exp_t'{tbl[i].cyc, tbl[i].kvo, tbl[i].cnt, tbl[i].emp, tbl[i].ful},
            $sformatf("row%0d", i));
    end
    apply(1'b0, 1'b1, 8'h00, exp_t'{0, 8'h00, 0, 1'b1, 1'b0}, "row_drain");

    // Descending fill: every insert lands at slot 0, so latency grows to DEPTH.
    for (int k = 15; k >= 0; k--) begin
      kk = 4'(k);
      apply(1'b1, 1'b0, {kk, kk},
            exp_t'{16 - k, {kk, kk}, 16 - k, 1'b0, (k == 0)},
            $sformatf("fill%0d", k));
    end
    apply(1'b1, 1'b0, 8'h0F, exp_t'{0, 8'h00, 16, 1'b0, 1'b1}, "enq_full");
    for (int i = 0; i < 16; i++) begin
      kk = 4'(i + 1);
      hv = (i < 15) ? {kk, kk} : 8'h00;
      apply(1'b0, 1'b1, 8'h00, exp_t'{0, hv, 15 - i, (i == 15), 1'b0},
            $sformatf("drain%0d", i));
    end

    // Requests arriving while busy must be ignored.
    apply(1'b1, 1'b0, 8'h1A, exp_t'{1, 8'h1A, 1, 1'b0, 1'b0}, "asc0");
    apply(1'b1, 1'b0, 8'h2A, exp_t'{1, 8'h1A, 2, 1'b0, 1'b0}, "asc1");
    apply(1'b1, 1'b0, 8'h3A, exp_t'{1, 8'h1A, 3, 1'b0, 1'b0}, "asc2");
    sb.push_back(exp_t'{4, 8'h05, 4, 1'b0, 1'b0});
    @(negedge clk);
    enq = 1'b1; kvi = 8'h05;
    @(posedge clk); #1;
    kvi = 8'hEE; deq = 1'b1;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      if (nb == 1) chk("mid_insert count", int'(dut.count), 3);
      if (nb == 3) begin enq = 1'b0; deq = 1'b0; end
      @(posedge clk); #1;
    end
    enq = 1'b0; deq = 1'b0;
    check_state("busy_ignore", nb);

    // Reset in the second INSERT cycle aborts the insertion.
    do_reset("reset1");
    apply(1'b1, 1'b0, 8'h11, exp_t'{1, 8'h11, 1, 1'b0, 1'b0}, "pre0");
    apply(1'b1, 1'b0, 8'h22, exp_t'{1, 8'h11, 2, 1'b0, 1'b0}, "pre1");
    apply(1'b1, 1'b0, 8'h33, exp_t'{1, 8'h11, 3, 1'b0, 1'b0}, "pre2");
    @(negedge clk);
    enq = 1'b1; kvi = 8'h00;
    @(posedge clk); #1;
    enq = 1'b0;
    chk("abort busy_cycle1", int'(busy), 1);
    @(posedge clk); #1;
    chk("abort busy_cycle2", int'(busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort count", int'(dut.count), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort kvo", int'(kvo), 0);
    chk("abort empty", int'(empty), 1);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 1'b0, 8'h66, exp_t'{1, 8'h66, 1, 1'b0, 1'b0}, "post_abort");

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pq_server.md
PQ_SERVER -- requirements
Module: pq_server

Interface
REQ-001 Parameter DEPTH, default 16: number of kv_t entries held; SHALL be at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 enq  input  1  enqueue request; kvi is sampled in the same cycle.
REQ-005 deq  input  1  dequeue request; removes the head entry.
REQ-006 kvi  input  kv_t (8)  entry to insert: key [7:4], value [3:0].
REQ-007 kvo  output  kv_t (8)  current head (minimum key); registered.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 empty  output  1  high when count == 0.
REQ-010 busy  output  1  high while an insertion is in progress.
REQ-011 Port names SHALL match the pq_if members so the block binds to the server modport with no renaming.

Function
REQ-012 Storage: a register array q[0..DEPTH-1] plus count (width $clog2(DEPTH+1)); q[0..count-1] is kept sorted by ascending key.
REQ-013 kvo SHALL equal q[0]; unused slots SHALL hold 8'h00, so kvo = 8'h00 when empty.
REQ-014 FSM states: IDLE and INSERT; busy SHALL be 1 exactly when the FSM is in INSERT.
REQ-015 enq accept: in IDLE with enq=1, deq=0 and full=0, latch kvi into hold, set idx=count, and go to INSERT.
REQ-016 INSERT step, one per cycle:
- if idx==0 or q[idx-1].key <= hold.key: write q[idx]=hold, count++, return to IDLE.
- otherwise: q[idx]=q[idx-1], idx--.
REQ-017 Equal keys SHALL dequeue in arrival order (stable ordering).
REQ-018 Insert latency is (count_at_accept - final_position + 1) cycles in INSERT; worst case is count+1.
REQ-019 count, empty and full SHALL update on the final INSERT cycle only.
REQ-020 deq accept: in IDLE with deq=1 and empty=0, in one cycle:
- q[i]=q[i+1] for i < count-1;
- q[count-1]=8'h00;
- count--;
- busy stays 0.
REQ-021 enq and deq in the same IDLE cycle: the deq SHALL be performed and the enq SHALL be dropped.
REQ-022 enq while full, deq while empty, and any request while busy SHALL be ignored with no state change.
REQ-023 Back-to-back operation: a new request SHALL be accepted in the first cycle after busy falls.

Reset
REQ-024 When rst=0 at a clock edge:
- all q entries = 8'h00; count = 0; FSM = IDLE;
- kvo = 8'h00, empty = 1, full = 0, busy = 0.
REQ-025 Reset during INSERT SHALL abort the insertion and discard the held entry.

Structure
REQ-026 kv_t (packed struct with 4-bit key and 4-bit value) and the FSM state enum SHALL live in pq_pkg; DEPTH stays a module parameter.
REQ-027 The block SHALL be a single module with no sub-module; the key comparison is inline.

Verification
REQ-028 Reset, then enq kvi=8'h55 -> busy for 1 cycle, then kvo=8'h55, empty=0.
REQ-029 Enq keys 3, 1, 2 (value = key) and wait for busy=0 after each, then deq three times -> kvo sequence is 8'h11, 8'h22, 8'h33, then empty=1 and kvo=8'h00.
REQ-030 Enq 16 distinct keys 15 down to 0 -> the last insert holds busy for 16 cycles; full=1; a further enq is ignored and count stays 16.
REQ-031 Enq 8'h4A then 8'h4B, deq twice -> 8'h4A is output before 8'h4B (ties are FIFO).
REQ-032 Enq and deq asserted together with count=2 -> count becomes 1 and kvi is not stored.
REQ-033 Assert rst=0 in the 2nd INSERT cycle with count=3 -> the next cycle shows count=0, busy=0, kvo=8'h00.
